// File: rtl/mux_pipe_nto1.sv
// mux_pipe_nto1: two-stage registered N-to-1 word mux with valid/ready back-pressure and scan mode
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data             N packed words, word k = in_data[k*WIDTH +: WIDTH]
//   in_sel / in_mode    direct select index / 1 = use internal scan pointer instead
//   scan_clr            synchronous clear of the scan pointer
//   in_valid, in_ready  request handshake
//   out_data, out_sel   selected word and the index that produced it
//   out_valid, out_ready output handshake
module mux_pipe_nto1 #(
    parameter int WIDTH = 32,
    parameter int N     = 32,
    parameter int GROUP = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N*WIDTH-1:0]     in_data,
    input  logic [$clog2(N)-1:0]   in_sel,
    input  logic                   in_mode,
    input  logic                   scan_clr,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(N)-1:0]   out_sel,
    output logic                   out_valid,
    input  logic                   out_ready
);
    localparam int SEL_W  = $clog2(N);
    localparam int GSEL_W = $clog2(GROUP);
    localparam int NG     = N / GROUP;
    localparam int HI_W   = NG > 1 ? $clog2(NG) : 1;
    logic [WIDTH-1:0] w_word [N];
    // Sized to a power of two so the final select needs no special case when N == GROUP;
    // entries at or above NG are never written and stay zero.
    logic [WIDTH-1:0] r_grp [2**HI_W];
    logic [HI_W-1:0]  r_s1_hi;
    logic [SEL_W-1:0] r_s1_sel;
    logic             r_s1_valid;
    logic [SEL_W-1:0] r_scan_ptr;
    logic [SEL_W-1:0] w_eff_sel;
    logic [SEL_W-1:0] w_lo;
    logic [HI_W-1:0]  w_hi;
    logic             w_s2_free;
    logic             w_s1_adv;
    logic             w_accept;
    for (genvar k = 0; k < N; k++) begin : g_word
        assign w_word[k] = in_data[k*WIDTH +: WIDTH];
    end
    assign w_eff_sel = in_mode ? r_scan_ptr : in_sel;
    assign w_lo      = w_eff_sel & SEL_W'(GROUP - 1);
    assign w_hi      = HI_W'(w_eff_sel >> GSEL_W);
    assign w_s2_free = !out_valid | out_ready;
    assign w_s1_adv  = r_s1_valid & w_s2_free;
    assign in_ready  = !r_s1_valid | w_s2_free;
    assign w_accept  = in_valid & in_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int g = 0; g < 2**HI_W; g++) r_grp[g] <= '0;
            r_s1_hi    <= '0;
            r_s1_sel   <= '0;
            r_s1_valid <= 1'b0;
            out_data   <= '0;
            out_sel    <= '0;
            out_valid  <= 1'b0;
            r_scan_ptr <= '0;
        end else begin
            if (w_accept) begin
                // group bases are GROUP-aligned, so OR-ing the low select bits forms the word index
                for (int g = 0; g < NG; g++) r_grp[g] <= w_word[SEL_W'(g*GROUP) | w_lo];
                r_s1_hi  <= w_hi;
                r_s1_sel <= w_eff_sel;
            end
            r_s1_valid <= w_accept | (r_s1_valid & !w_s1_adv);
            if (w_s1_adv) begin
                out_data <= r_grp[r_s1_hi];
                out_sel  <= r_s1_sel;
            end
            out_valid <= w_s1_adv | (out_valid & !out_ready);
            // N is a power of two, so the increment wraps from N-1 to 0 on its own
            r_scan_ptr <= scan_clr ? '0 : (w_accept & in_mode) ? r_scan_ptr + SEL_W'(1) : r_scan_ptr;
        end
    end
endmodule

// File: tb/tb_mux_pipe_nto1.sv
// tb_mux_pipe_nto1: directed checks of the pipelined N-to-1 mux plus a randomised sweep of two other sizes
module tb_mux_pipe_nto1;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [32*32-1:0] in_data;
    logic [4:0] in_sel, out_sel;
    logic in_mode, scan_clr, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] out_data;
    logic [64*8-1:0] b_data;
    logic [5:0] b_sel, b_osel;
    logic b_valid, b_iready, b_ovalid, b_oready;
    logic [7:0] b_odata;
    logic [8*8-1:0] c_data;
    logic [2:0] c_sel, c_osel;
    logic c_valid, c_iready, c_ovalid, c_oready;
    logic [7:0] c_odata;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_pipe_nto1 #(.WIDTH(32), .N(32), .GROUP(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel), .in_mode(in_mode),
        .scan_clr(scan_clr), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready));

    mux_pipe_nto1 #(.WIDTH(8), .N(64), .GROUP(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_sel(b_sel), .in_mode(1'b0),
        .scan_clr(1'b0), .in_valid(b_valid), .in_ready(b_iready), .out_data(b_odata),
        .out_sel(b_osel), .out_valid(b_ovalid), .out_ready(b_oready));

    mux_pipe_nto1 #(.WIDTH(8), .N(8), .GROUP(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_sel(c_sel), .in_mode(1'b0),
        .scan_clr(1'b0), .in_valid(c_valid), .in_ready(c_iready), .out_data(c_odata),
        .out_sel(c_osel), .out_valid(c_ovalid), .out_ready(c_oready));

    task automatic test_reset();
        #2;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if (out_sel !== 5'd0) begin failures++; $display("FAIL reset_out_sel: got %0d want 0", out_sel); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (b_ovalid !== 1'b0 || c_ovalid !== 1'b0) begin failures++; $display("FAIL reset_sweep_valid: got %b%b want 00", b_ovalid, c_ovalid); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_direct();
        int sels[5] = '{0, 7, 8, 31, 17};
        out_ready = 1'b1;
        in_mode = 1'b0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            in_valid = c < 5;
            in_sel = c < 5 ? 5'(sels[c]) : 5'd0;
            #1;
            checks++; if (out_valid !== (c >= 2)) begin failures++; $display("FAIL direct_valid c=%0d: got %b want %b", c, out_valid, c >= 2); end
            if (c >= 2) begin
                checks++; if (out_data !== 32'hA000_0000 + 32'(sels[c-2])) begin failures++; $display("FAIL direct_data c=%0d: got %h want %h", c, out_data, 32'hA000_0000 + 32'(sels[c-2])); end
                checks++; if (out_sel !== 5'(sels[c-2])) begin failures++; $display("FAIL direct_sel c=%0d: got %0d want %0d", c, out_sel, sels[c-2]); end
            end
        end
    endtask

    task automatic test_backpressure();
        int nxt = 1;
        int e = 1;
        in_mode = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = c >= 5;
            in_valid = nxt <= 6;
            in_sel = 5'(nxt);
            #1;
            if (c < 2) begin
                checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_early c=%0d: got %b want 1", c, in_ready); end
            end else if (c < 5) begin
                checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full c=%0d: got %b want 0", c, in_ready); end
                checks++; if (out_valid !== 1'b1 || out_data !== 32'hA000_0001) begin failures++; $display("FAIL bp_hold c=%0d: got v=%b d=%h want v=1 d=a0000001", c, out_valid, out_data); end
            end
            if (out_valid && out_ready) begin
                checks++; if (out_sel !== 5'(e) || out_data !== 32'hA000_0000 + 32'(e)) begin failures++; $display("FAIL bp_order: got sel=%0d d=%h want sel=%0d", out_sel, out_data, e); end
                e++;
            end
            if (in_valid && in_ready) nxt++;
        end
        checks++; if (e !== 7) begin failures++; $display("FAIL bp_count: got %0d words want 6", e - 1); end
    endtask

    task automatic test_scan();
        @(negedge clk);
        in_valid = 1'b0;
        scan_clr = 1'b1;
        in_mode = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            scan_clr = 1'b0;
            in_valid = c < 34;
            #1;
            if (c >= 2) begin
                checks++; if (out_valid !== 1'b1 || out_sel !== 5'((c-2) % 32) || out_data !== 32'hA000_0000 + 32'((c-2) % 32)) begin failures++; $display("FAIL scan_wrap item=%0d: got v=%b sel=%0d d=%h want sel=%0d", c-2, out_valid, out_sel, out_data, (c-2) % 32); end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        scan_clr = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            scan_clr = c == 9;
            in_valid = c < 12;
            #1;
            if (c >= 2) begin
                checks++; if (out_valid !== 1'b1 || out_sel !== 5'(c-2 <= 9 ? c-2 : c-12)) begin failures++; $display("FAIL scan_clr item=%0d: got v=%b sel=%0d want %0d", c-2, out_valid, out_sel, c-2 <= 9 ? c-2 : c-12); end
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_mode = 1'b0;
        scan_clr = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_sel = 5'd3;
        @(negedge clk);
        in_sel = 5'd4;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b1 || out_sel !== 5'd3 || in_ready !== 1'b0) begin failures++; $display("FAIL rst_pre_full: got v=%b sel=%0d rdy=%b want 1 3 0", out_valid, out_sel, in_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_sel !== 5'd0) begin failures++; $display("FAIL rst_async_out: got v=%b d=%h sel=%0d want 0 0 0", out_valid, out_data, out_sel); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready: got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_sel = 5'd5;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            checks++; if (out_valid !== (c == 2)) begin failures++; $display("FAIL rst_after_valid c=%0d: got %b want %b", c, out_valid, c == 2); end
            if (c == 2) begin
                checks++; if (out_sel !== 5'd5 || out_data !== 32'hA000_0005) begin failures++; $display("FAIL rst_after_item: got sel=%0d d=%h want 5 a0000005", out_sel, out_data); end
            end
        end
    endtask

    task automatic test_mode_switch();
        int exp_sel[6] = '{20, 0, 20, 1, 20, 2};
        @(negedge clk);
        in_valid = 1'b0;
        scan_clr = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            scan_clr = 1'b0;
            in_valid = c < 6;
            in_mode = 1'(c % 2);
            in_sel = 5'd20;
            #1;
            if (c >= 2) begin
                checks++; if (out_valid !== 1'b1 || out_sel !== 5'(exp_sel[c-2]) || out_data !== 32'hA000_0000 + 32'(exp_sel[c-2])) begin failures++; $display("FAIL mode_switch item=%0d: got v=%b sel=%0d want %0d", c-2, out_valid, out_sel, exp_sel[c-2]); end
            end
        end
        in_mode = 1'b0;
    endtask

    task automatic test_sweep();
        int qb[$];
        int qc[$];
        int nb = 0;
        int nc = 0;
        int e;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            b_valid = $urandom_range(0, 3) != 0;
            b_sel = 6'($urandom_range(0, 63));
            b_oready = $urandom_range(0, 3) != 0;
            c_valid = $urandom_range(0, 3) != 0;
            c_sel = 3'($urandom_range(0, 7));
            c_oready = $urandom_range(0, 2) != 0;
            #1;
            if (b_ovalid && b_oready) begin
                checks++;
                if (qb.size() == 0) begin failures++; $display("FAIL sweep64_extra: got sel=%0d want none", b_osel); end
                else begin
                    e = qb.pop_front();
                    if (b_osel !== 6'(e) || b_odata !== 8'(e*3 + 5)) begin failures++; $display("FAIL sweep64: got sel=%0d d=%h want sel=%0d d=%h", b_osel, b_odata, e, 8'(e*3 + 5)); end
                end
                nb++;
            end
            if (b_valid && b_iready) qb.push_back(int'(b_sel));
            if (c_ovalid && c_oready) begin
                checks++;
                if (qc.size() == 0) begin failures++; $display("FAIL sweep8_extra: got sel=%0d want none", c_osel); end
                else begin
                    e = qc.pop_front();
                    if (c_osel !== 3'(e) || c_odata !== 8'(e*17 + 1)) begin failures++; $display("FAIL sweep8: got sel=%0d d=%h want sel=%0d d=%h", c_osel, c_odata, e, 8'(e*17 + 1)); end
                end
                nc++;
            end
            if (c_valid && c_iready) qc.push_back(int'(c_sel));
            if (qb.size() > 2 || qc.size() > 2) begin
                checks++; failures++;
                $display("FAIL sweep_inflight: got %0d/%0d items want <=2", qb.size(), qc.size());
            end
        end
        checks++; if (nb < 100 || nc < 100) begin failures++; $display("FAIL sweep_throughput: got %0d/%0d words want >=100", nb, nc); end
    endtask

    initial begin
        in_valid = 1'b0;
        in_sel = '0;
        in_mode = 1'b0;
        scan_clr = 1'b0;
        out_ready = 1'b0;
        b_valid = 1'b0;
        b_sel = '0;
        b_oready = 1'b0;
        c_valid = 1'b0;
        c_sel = '0;
        c_oready = 1'b0;
        for (int k = 0; k < 32; k++) in_data[k*32 +: 32] = 32'hA000_0000 + 32'(k);
        for (int k = 0; k < 64; k++) b_data[k*8 +: 8] = 8'(k*3 + 5);
        for (int k = 0; k < 8; k++) c_data[k*8 +: 8] = 8'(k*17 + 1);
        test_reset();
        test_direct();
        test_backpressure();
        test_scan();
        test_async_reset();
        test_mode_switch();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
